// File: rtl/reg_bank_pkg.sv
// rtl/reg_bank_pkg.sv - shared FSM state types and error data constant for the register bank
package reg_bank_pkg;

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  // Error pattern returned for out-of-range accesses; sliced down to DATA_WIDTH by users.
  localparam int MAX_DATA_WIDTH = 64;
  localparam logic [MAX_DATA_WIDTH-1:0] ERR_DATA = '1;

endpackage

// File: rtl/reg_if.sv
// rtl/reg_if.sv - register bus with write, write-response, read-address and read-data channels
interface reg_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);

  logic                  wvalid;
  logic                  wready;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;

  logic                  bvalid;
  logic                  bready;
  logic [DATA_WIDTH-1:0] bdata;

  logic                  arvalid;
  logic                  aready;
  logic [ADDR_WIDTH-1:0] raddr;

  logic                  rvalid;
  logic                  rready;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output wvalid, waddr, wdata, bready, arvalid, raddr, rready,
    input  wready, bvalid, bdata, aready, rvalid, rdata
  );

  modport slave (
    input  wvalid, waddr, wdata, bready, arvalid, raddr, rready,
    output wready, bvalid, bdata, aready, rvalid, rdata
  );

endinterface

// File: rtl/reg_bank_cell.sv
// rtl/reg_bank_cell.sv - one CSR with bus-over-hardware write priority, read-only gating and write strobe
module reg_bank_cell
  import reg_bank_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter bit READ_ONLY  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  bus_sel,
  input  logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  hw_we,
  input  logic [DATA_WIDTH-1:0] hw_wdata,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  wr_pulse
);

  // A bus write only lands on writable registers; hardware may write any register.
  logic bus_commit;
  assign bus_commit = bus_sel && !READ_ONLY;

  // Storage update and one-cycle commit strobe (aligned with the first response cycle).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q        <= '0;
      wr_pulse <= 1'b0;
    end else begin
      wr_pulse <= bus_commit;
      if (bus_commit) begin
        q <= bus_wdata;
      end else if (hw_we) begin
        q <= hw_wdata;
      end
    end
  end

endmodule

// File: rtl/reg_bank_slave.sv
// rtl/reg_bank_slave.sv - CSR bank endpoint with independent write/response and read/data channels
module reg_bank_slave
  import reg_bank_pkg::*;
#(
  parameter int                  ADDR_WIDTH = 5,
  parameter int                  DATA_WIDTH = 32,
  parameter int                  NUM_REGS   = 32,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  reg_if.slave                           bus,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            wr_pulse,
  input  logic [NUM_REGS-1:0]            hw_we,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_wdata
);

  localparam logic [DATA_WIDTH-1:0] ERR = ERR_DATA[DATA_WIDTH-1:0];

  w_state_e w_state;
  r_state_e r_state;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic w_hs;
  logic r_hs;

  assign bus.wready = (w_state == W_IDLE);
  assign bus.bvalid = (w_state == W_RESP);
  assign bus.aready = (r_state == R_IDLE);
  assign bus.rvalid = (r_state == R_DATA);

  assign w_hs = bus.wvalid && bus.wready;
  assign r_hs = bus.arvalid && bus.aready;

  // Write-side lookup: full-width address compare, so addresses past NUM_REGS never alias.
  logic                  w_hit;
  logic                  w_ro;
  logic [DATA_WIDTH-1:0] w_cur;
  always_comb begin
    w_hit = 1'b0;
    w_ro  = 1'b0;
    w_cur = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (bus.waddr == ADDR_WIDTH'(i)) begin
        w_hit = 1'b1;
        w_ro  = RO_MASK[i];
        w_cur = regs[i];
      end
    end
  end

  // Read mux; sees pre-edge register contents, so a colliding write is not visible yet.
  logic                  r_hit;
  logic [DATA_WIDTH-1:0] r_cur;
  always_comb begin
    r_hit = 1'b0;
    r_cur = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (bus.raddr == ADDR_WIDTH'(i)) begin
        r_hit = 1'b1;
        r_cur = regs[i];
      end
    end
  end

  // Register cells; each decodes its own bus select from the write handshake.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cell
    logic sel;
    assign sel = w_hs && (bus.waddr == ADDR_WIDTH'(g));

    reg_bank_cell #(
      .DATA_WIDTH (DATA_WIDTH),
      .READ_ONLY  (RO_MASK[g])
    ) u_cell (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus_sel   (sel),
      .bus_wdata (bus.wdata),
      .hw_we     (hw_we[g]),
      .hw_wdata  (hw_wdata[g*DATA_WIDTH +: DATA_WIDTH]),
      .q         (regs[g]),
      .wr_pulse  (wr_pulse[g])
    );

    assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end

  // Write FSM: capture the response word at the handshake, hold it until bready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state   <= W_IDLE;
      bus.bdata <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (w_hs) begin
            w_state <= W_RESP;
            if (!w_hit) begin
              bus.bdata <= ERR;
            end else if (w_ro) begin
              bus.bdata <= w_cur;
            end else begin
              bus.bdata <= bus.wdata;
            end
          end
        end
        W_RESP: begin
          if (bus.bready) begin
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read FSM: capture read data at the address handshake, hold it until rready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= R_IDLE;
      bus.rdata <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (r_hs) begin
            r_state   <= R_DATA;
            bus.rdata <= r_hit ? r_cur : ERR;
          end
        end
        R_DATA: begin
          if (bus.rready) begin
            r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule
